vec_mem_sequencer: RTL and testbench

- Sequences multi-beat vector memory operations for the MEM stage.
- A vector load (into WVR/SVR) or a vector store carries VL; VL+1 word beats must cross the single-word data memory port.
- The block freezes the EX/MEM pipeline register and everything upstream while the beats are in flight.
- It drives the data memory handshake and the per-lane vector register write port.

---
 rtl/vec_mem_sequencer_if.sv | 22 ++
 rtl/vec_mem_sequencer.sv | 113 +++++++++++
 tb/tb_vec_mem_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/vec_mem_sequencer_if.sv
// Single-word data memory handshake between the vector memory sequencer
// (master) and the data memory (slave).
interface vec_mem_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/vec_mem_sequencer.sv
// MEM-stage vector load/store sequencer: splits one vector op into vl+1 word
// beats on the data memory port while stalling the upstream pipeline.
module vec_mem_sequencer #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                is_store,
    input  logic [1:0]          vl,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [127:0]        store_data,
    input  logic                flush,
    vec_mem_sequencer_if.master mem,
    output logic                vreg_we,
    output logic [1:0]          vreg_lane,
    output logic [31:0]         vreg_wdata,
    output logic                stall,
    output logic                done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        lane_q,  lane_d;
    logic [1:0]        last_q,  last_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              we_q,    we_d;
    logic [127:0]      sdata_q, sdata_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            last_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            sdata_q <= sdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        last_d  = last_q;
        addr_d  = addr_q;
        we_d    = we_q;
        sdata_d = sdata_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    state_d = S_BUSY;
                    lane_d  = '0;
                    last_d  = vl;
                    addr_d  = base_addr;
                    we_d    = is_store;
                    sdata_d = store_data;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                    lane_d  = '0;
                end else if (mem.mem_ready) begin
                    if (lane_q == last_q) begin
                        state_d = S_DONE;
                        lane_d  = '0;
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Every output is qualified with reset_n so it drops to zero the moment
    // reset asserts, even though start feeds stall combinationally.
    logic              in_idle, in_busy, in_done, load_beat;
    logic [ADDR_W-1:0] beat_addr;
    logic [31:0]       lane_word;

    assign in_idle   = reset_n && (state_q == S_IDLE);
    assign in_busy   = reset_n && (state_q == S_BUSY);
    assign in_done   = reset_n && (state_q == S_DONE);
    assign beat_addr = addr_q + ADDR_W'(lane_q) * ADDR_W'(WORD_BYTES);
    assign lane_word = sdata_q[{lane_q, 5'b00000} +: 32];
    assign load_beat = in_busy && mem.mem_ready && !we_q && !flush;

    assign mem.mem_req   = in_busy;
    assign mem.mem_we    = in_busy && we_q;
    assign mem.mem_addr  = in_busy ? beat_addr : '0;
    assign mem.mem_wdata = in_busy ? lane_word : '0;

    assign vreg_we    = load_beat;
    assign vreg_lane  = load_beat ? lane_q : '0;
    assign vreg_wdata = load_beat ? mem.mem_rdata : '0;

    assign stall = (in_idle && start && !flush) || (in_busy && !flush);
    assign done  = in_done;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer: inputs change on the falling edge and
// outputs are checked 1 ns later, well away from the rising edge.
module tb_vec_mem_sequencer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         is_store;
    logic [1:0]   vl;
    logic [31:0]  base_addr;
    logic [127:0] store_data;
    logic         flush;
    logic         vreg_we;
    logic [1:0]   vreg_lane;
    logic [31:0]  vreg_wdata;
    logic         stall;
    logic         done;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    vec_mem_sequencer_if #(.ADDR_W(32)) mif();

    vec_mem_sequencer #(.ADDR_W(32), .WORD_BYTES(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .is_store   (is_store),
        .vl         (vl),
        .base_addr  (base_addr),
        .store_data (store_data),
        .flush      (flush),
        .mem        (mif),
        .vreg_we    (vreg_we),
        .vreg_lane  (vreg_lane),
        .vreg_wdata (vreg_wdata),
        .stall      (stall),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic ex(input string tag,
                      input logic [31:0] req, input logic [31:0] we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] vwe, input logic [31:0] vlane,
                      input logic [31:0] vwdata, input logic [31:0] stl,
                      input logic [31:0] dn);
        chk({tag, ".mem_req"},    32'(mif.mem_req),   req);
        chk({tag, ".mem_we"},     32'(mif.mem_we),    we);
        chk({tag, ".mem_addr"},   mif.mem_addr,       addr);
        chk({tag, ".mem_wdata"},  mif.mem_wdata,      wdata);
        chk({tag, ".vreg_we"},    32'(vreg_we),       vwe);
        chk({tag, ".vreg_lane"},  32'(vreg_lane),     vlane);
        chk({tag, ".vreg_wdata"}, vreg_wdata,         vwdata);
        chk({tag, ".stall"},      32'(stall),         stl);
        chk({tag, ".done"},       32'(done),          dn);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset_n        = 1'b0;
        start          = 1'b1;
        is_store       = 1'b0;
        vl             = 2'd0;
        base_addr      = '0;
        store_data     = '0;
        flush          = 1'b0;
        mif.mem_ready  = 1'b0;
        mif.mem_rdata  = '0;
        #2 ex("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        step(); reset_n = 1'b1; start = 1'b0;
        #1 ex("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load vl=3 at 0x100, memory always ready.
        step(); start = 1'b1; is_store = 1'b0; vl = 2'd3; base_addr = 32'h100;
        store_data = '0; mif.mem_ready = 1'b1;
        #1 ex("ld3.start", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(); mif.mem_rdata = 32'hA0 + i;
            #1 ex($sformatf("ld3.beat%0d", i), 1, 0, 32'h100 + 4 * i, 0, 1, i, 32'hA0 + i, 1, 0);
        end
        step(); start = 1'b0;
        #1 ex("ld3.done", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        #1 ex("ld3.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Store vl=0 at 0x20.
        step(); start = 1'b1; is_store = 1'b1; vl = 2'd0; base_addr = 32'h20;
        store_data = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        #1 ex("st0.start", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        #1 ex("st0.beat", 1, 1, 32'h20, 32'hDEADBEEF, 0, 0, 0, 1, 0);
        step(); start = 1'b0;
        #1 ex("st0.done", 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Load vl=1 at 0x200 with three wait cycles per beat.
        step(); start = 1'b1; is_store = 1'b0; vl = 2'd1; base_addr = 32'h200;
        store_data = '0; mif.mem_ready = 1'b0;
        #1 ex("ld1.start", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < 3; w++) begin
                step(); mif.mem_ready = 1'b0; mif.mem_rdata = 32'hFFFF;
                #1 ex($sformatf("ld1.b%0dw%0d", b, w), 1, 0, 32'h200 + 4 * b, 0, 0, 0, 0, 1, 0);
            end
            step(); mif.mem_ready = 1'b1; mif.mem_rdata = 32'h55 + b;
            #1 ex($sformatf("ld1.b%0d", b), 1, 0, 32'h200 + 4 * b, 0, 1, b, 32'h55 + b, 1, 0);
        end
        step(); start = 1'b0;
        #1 ex("ld1.done", 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // start together with flush in IDLE launches nothing.
        step(); start = 1'b1; flush = 1'b1;
        #1 ex("iflush", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); start = 1'b0; flush = 1'b0;
        #1 ex("iflush.next", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Store vl=3 at 0x300, flushed while lane 1 waits.
        step(); start = 1'b1; is_store = 1'b1; vl = 2'd3; base_addr = 32'h300;
        store_data = {32'h44440003, 32'h44440002, 32'h44440001, 32'h44440000};
        mif.mem_ready = 1'b1;
        #1 ex("st3.start", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        #1 ex("st3.l0", 1, 1, 32'h300, 32'h44440000, 0, 0, 0, 1, 0);
        step(); mif.mem_ready = 1'b0; flush = 1'b1;
        #1 ex("st3.flush", 1, 1, 32'h304, 32'h44440001, 0, 0, 0, 0, 0);
        step(); flush = 1'b0; start = 1'b0;
        #1 ex("st3.after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); mif.mem_ready = 1'b1;
        #1 ex("st3.after2", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a load (lane 2).
        step(); start = 1'b1; is_store = 1'b0; vl = 2'd3; base_addr = 32'h400;
        store_data = '0; mif.mem_ready = 1'b1;
        #1 ex("rst.start", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(); mif.mem_rdata = 32'h70 + i;
            #1 ex($sformatf("rst.beat%0d", i), 1, 0, 32'h400 + 4 * i, 0, 1, i, 32'h70 + i, 1, 0);
        end
        #1 reset_n = 1'b0;
        #1 ex("rst.mid", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); reset_n = 1'b1; start = 1'b0;
        #1 ex("rst.rel", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        #1 ex("rst.rel2", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Address wrap past the top of the address space.
        step(); start = 1'b1; is_store = 1'b0; vl = 2'd1; base_addr = 32'hFFFFFFFC;
        mif.mem_ready = 1'b1;
        #1 ex("wrap.start", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(); mif.mem_rdata = 32'h1;
        #1 ex("wrap.b0", 1, 0, 32'hFFFFFFFC, 0, 1, 0, 32'h1, 1, 0);
        step(); mif.mem_rdata = 32'h2;
        #1 ex("wrap.b1", 1, 0, 32'h0, 0, 1, 1, 32'h2, 1, 0);
        step(); start = 1'b0;
        #1 ex("wrap.done", 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // start held high through DONE: relaunch only from IDLE.
        step(); start = 1'b1; is_store = 1'b0; vl = 2'd0; base_addr = 32'h40;
        mif.mem_rdata = 32'h99;
        #1 ex("hold.start", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        #1 ex("hold.b0", 1, 0, 32'h40, 0, 1, 0, 32'h99, 1, 0);
        step();
        #1 ex("hold.done", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        #1 ex("hold.idle", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        #1 ex("hold.relaunch", 1, 0, 32'h40, 0, 1, 0, 32'h99, 1, 0);
        step(); start = 1'b0;
        #1 ex("hold.done2", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        #1 ex("hold.idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
